prod_accumulator: RTL and testbench

//  Downstream stage of the 4x4 shift-add multiplier. Consumes one product per

---
 rtl/prod_accumulator.sv | 112 +++++++++++
 tb/tb_prod_accumulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/prod_accumulator.sv
// prod_accumulator
//   Downstream stage of the 4x4 shift-add multiplier. It sums every LEN
//   accepted products into one group total. Each finished total is handed to
//   a one-entry output register with a valid/ready handshake and an overflow
//   tag. Accumulation never stalls, because the multiplier cannot be held off.
//   If a group finishes while the output register is still occupied, that
//   group's result is dropped and the sticky overrun flag is set.
//
// Ports
//   clk        in   single clock; all state changes on posedge
//   rst        in   synchronous reset, active-high
//   prod_valid in   prod carries a new product this cycle
//   prod       in   PROD_W unsigned product, zero-extended to ACC_W
//   clear      in   abandon the current partial group (same-cycle prod dropped)
//   sum_valid  out  sum/sum_ovf hold a completed group
//   sum_ready  in   consumer takes sum when sum_valid && sum_ready
//   sum        out  ACC_W group total modulo 2^ACC_W
//   sum_ovf    out  group total exceeded 2^ACC_W-1
//   count      out  products accepted in the current group
//   overrun    out  sticky: a completed group was discarded (cleared by rst)
module prod_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prod_valid,
  input  logic [PROD_W-1:0]       prod,
  input  logic                    clear,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic [ACC_W-1:0]        sum,
  output logic                    sum_ovf,
  output logic [$clog2(LEN)-1:0]  count,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(LEN);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_grp_ovf;
  logic [ACC_W-1:0] r_sum;
  logic             r_sum_ovf;
  logic             r_sum_valid;
  logic             r_overrun;

  logic [ACC_W:0]   w_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_done;
  logic             w_free;
  logic             w_consume;

  // One extra bit catches the carry out of this addition; grp_ovf keeps any
  // earlier carry within the same group.
  assign w_nxt     = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign w_accept  = prod_valid && !clear;
  assign w_last    = (r_cnt == CNT_W'(LEN - 1));
  assign w_done    = w_accept && w_last;
  assign w_free    = !r_sum_valid || sum_ready;
  assign w_consume = r_sum_valid && sum_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_grp_ovf   <= 1'b0;
      r_sum       <= '0;
      r_sum_ovf   <= 1'b0;
      r_sum_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // Accumulator side
      if (clear) begin
        r_acc     <= '0;
        r_cnt     <= '0;
        r_grp_ovf <= 1'b0;
      end else if (prod_valid) begin
        if (w_last) begin
          r_acc     <= '0;
          r_cnt     <= '0;
          r_grp_ovf <= 1'b0;
        end else begin
          r_acc     <= w_nxt[ACC_W-1:0];
          r_cnt     <= r_cnt + CNT_W'(1);
          r_grp_ovf <= r_grp_ovf | w_nxt[ACC_W];
        end
      end

      // Output register: a load on a free slot wins over the consume, which
      // allows a consume and a load in the same cycle.
      if (w_done && w_free) begin
        r_sum       <= w_nxt[ACC_W-1:0];
        r_sum_ovf   <= r_grp_ovf | w_nxt[ACC_W];
        r_sum_valid <= 1'b1;
      end else if (w_done) begin
        r_overrun   <= 1'b1;
      end else if (w_consume) begin
        r_sum_valid <= 1'b0;
      end
    end
  end

  assign sum_valid = r_sum_valid;
  assign sum       = r_sum;
  assign sum_ovf   = r_sum_ovf;
  assign count     = r_cnt;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_prod_accumulator.sv
// tb_prod_accumulator
//   Drives two accumulators (ACC_W=16 and ACC_W=9) with the same stimulus.
//   A group-level reference model holds the products of the current group as
//   an exact integer total and reduces it modulo 2^ACC_W only when the group
//   completes. Directed scenarios come first, then a randomized run.
module tb_prod_accumulator;

  localparam int PW  = 8;
  localparam int LEN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          prod_valid = 1'b0;
  logic [PW-1:0] prod = '0;
  logic          clear = 1'b0;
  logic          sum_ready = 1'b0;

  logic          sv16, ovf16, ovr16;
  logic [15:0]   sum16;
  logic [1:0]    cnt16;
  logic          sv9, ovf9, ovr9;
  logic [8:0]    sum9;
  logic [1:0]    cnt9;

  prod_accumulator #(.PROD_W(PW), .ACC_W(16), .LEN(LEN)) u_dut16 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod(prod), .clear(clear),
    .sum_valid(sv16), .sum_ready(sum_ready), .sum(sum16), .sum_ovf(ovf16),
    .count(cnt16), .overrun(ovr16)
  );

  prod_accumulator #(.PROD_W(PW), .ACC_W(9), .LEN(LEN)) u_dut9 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod(prod), .clear(clear),
    .sum_valid(sv9), .sum_ready(sum_ready), .sum(sum9), .sum_ovf(ovf9),
    .count(cnt9), .overrun(ovr9)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, index 0 = ACC_W 16, index 1 = ACC_W 9
  int     aw[2] = '{16, 9};
  longint m_total[2];
  int     m_cnt[2];
  bit     m_valid[2];
  longint m_sum[2];
  bit     m_ovf[2];
  bit     m_ovr[2];

  task automatic model(input int k, input bit r, input bit pv, input int p,
                       input bit c, input bit rd);
    bit     consume;
    bit     free_slot;
    longint limit;
    consume   = m_valid[k] && rd;
    free_slot = !m_valid[k] || rd;
    limit     = longint'(1) << aw[k];
    if (r) begin
      m_total[k] = 0; m_cnt[k] = 0; m_valid[k] = 0;
      m_sum[k] = 0; m_ovf[k] = 0; m_ovr[k] = 0;
    end else if (c) begin
      m_total[k] = 0; m_cnt[k] = 0;
      if (consume) m_valid[k] = 0;
    end else if (pv) begin
      m_total[k] += p;
      m_cnt[k]++;
      if (m_cnt[k] == LEN) begin
        if (free_slot) begin
          m_sum[k]   = m_total[k] % limit;
          m_ovf[k]   = (m_total[k] >= limit);
          m_valid[k] = 1;
        end else begin
          m_ovr[k] = 1;
        end
        m_total[k] = 0; m_cnt[k] = 0;
      end else if (consume) begin
        m_valid[k] = 0;
      end
    end else if (consume) begin
      m_valid[k] = 0;
    end
  endtask

  task automatic compare_all();
    check("valid16", 64'(sv16),  64'(m_valid[0]));
    check("sum16",   64'(sum16), 64'(m_sum[0]));
    check("ovf16",   64'(ovf16), 64'(m_ovf[0]));
    check("count16", 64'(cnt16), 64'(m_cnt[0]));
    check("ovr16",   64'(ovr16), 64'(m_ovr[0]));
    check("valid9",  64'(sv9),   64'(m_valid[1]));
    check("sum9",    64'(sum9),  64'(m_sum[1]));
    check("ovf9",    64'(ovf9),  64'(m_ovf[1]));
    check("count9",  64'(cnt9),  64'(m_cnt[1]));
    check("ovr9",    64'(ovr9),  64'(m_ovr[1]));
  endtask

  // Inputs change at posedge+1; outputs are sampled at the next posedge+1.
  task automatic step(input bit r, input bit pv, input int p, input bit c, input bit rd);
    rst = r; prod_valid = pv; prod = PW'(p); clear = c; sum_ready = rd;
    for (int k = 0; k < 2; k++) model(k, r, pv, p, c, rd);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
  endtask

  task automatic group(input int a, input int b, input int c, input int d, input bit rd);
    step(0, 1, a, 0, rd);
    step(0, 1, b, 0, rd);
    step(0, 1, c, 0, rd);
    step(0, 1, d, 0, rd);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", 64'(sv16), 64'd0);
    check("rst_sum",   64'(sum16), 64'd0);
    check("rst_ovr",   64'(ovr16), 64'd0);

    // T1: 10+20+30+40, valid the cycle after the 4th product
    group(10, 20, 30, 40, 1);
    check("t1_valid", 64'(sv16), 64'd1);
    check("t1_sum",   64'(sum16), 64'd100);
    check("t1_ovf",   64'(ovf16), 64'd0);
    check("t1_count", 64'(cnt16), 64'd0);

    // T2: 255 x4 wraps in 9 bits, next group does not inherit the tag
    group(255, 255, 255, 255, 1);
    check("t2_sum9",  64'(sum9),  64'd508);
    check("t2_ovf9",  64'(ovf9),  64'd1);
    check("t2_sum16", 64'(sum16), 64'd1020);
    check("t2_ovf16", 64'(ovf16), 64'd0);
    group(1, 1, 1, 1, 1);
    check("t2b_sum9", 64'(sum9), 64'd4);
    check("t2b_ovf9", 64'(ovf9), 64'd0);

    // T3: held output, second group dropped, overrun sticks
    step(0, 0, 0, 0, 1);
    group(1, 1, 1, 1, 0);
    group(2, 2, 2, 2, 0);
    check("t3_sum",   64'(sum16), 64'd4);
    check("t3_ovr",   64'(ovr16), 64'd1);
    check("t3_valid", 64'(sv16),  64'd1);
    step(0, 0, 0, 0, 1);
    check("t3_drain", 64'(sv16), 64'd0);
    check("t3_ovr2",  64'(ovr16), 64'd1);

    // T4: consume and load on the same cycle
    do_reset();
    group(1, 1, 1, 1, 0);
    step(0, 1, 3, 0, 0);
    step(0, 1, 3, 0, 0);
    step(0, 1, 3, 0, 0);
    step(0, 1, 3, 0, 1);
    check("t4_valid", 64'(sv16),  64'd1);
    check("t4_sum",   64'(sum16), 64'd12);
    check("t4_ovr",   64'(ovr16), 64'd0);

    // T5: clear with a same-cycle product discards it
    do_reset();
    step(0, 1, 5, 0, 1);
    step(0, 1, 6, 0, 1);
    step(0, 1, 7, 1, 1);
    check("t5_count", 64'(cnt16), 64'd0);
    group(1, 2, 3, 4, 1);
    check("t5_sum", 64'(sum16), 64'd10);

    // T6: reset mid-group with a held output
    do_reset();
    group(1, 1, 1, 1, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    check("t6_pre_valid", 64'(sv16), 64'd1);
    do_reset();
    check("t6_valid", 64'(sv16),  64'd0);
    check("t6_sum",   64'(sum16), 64'd0);
    check("t6_count", 64'(cnt16), 64'd0);
    group(2, 2, 2, 2, 1);
    check("t6_sum2", 64'(sum16), 64'd8);

    // Randomized run, with gaps, clears, backpressure and rare resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 1),
           ($urandom_range(0, 9) < 7),
           int'($urandom_range(0, 255)),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
